// File: rtl/serial_subtractor.sv
// Bit-serial ripple subtractor: computes a - b - bin one bit per clock,
// LSB first, with a single full-subtractor cell and a registered borrow.
// A start/busy/done handshake lets a controller issue operations
// back-to-back; diff and bout change only when an operation completes.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
    output logic             done
);

    // Counter only needs to reach WIDTH-1; guard the WIDTH=1 corner of clog2.
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] a_sh_r, a_sh_s;
    logic [WIDTH-1:0] b_sh_r, b_sh_s;
    logic [WIDTH-1:0] res_r, res_s;
    logic [WIDTH-1:0] diff_r, diff_s;
    logic             brw_r, brw_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic             bout_r, bout_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic [1:0]       cell_s;
    logic [WIDTH-1:0] res_next_s;

    // One full-subtractor cell: returns {borrow_out, difference_bit}.
    function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bi);
        logic d;
        logic bo;
        d  = x ^ y ^ bi;
        bo = (~x & y) | (~(x ^ y) & bi);
        return {bo, d};
    endfunction

    assign diff = diff_r;
    assign bout = bout_r;
    assign busy = busy_r;
    assign done = done_r;

    // Next-state and datapath logic; every register holds unless told otherwise.
    always_comb begin
        state_s    = state_r;
        a_sh_s     = a_sh_r;
        b_sh_s     = b_sh_r;
        res_s      = res_r;
        diff_s     = diff_r;
        brw_s      = brw_r;
        cnt_s      = cnt_r;
        bout_s     = bout_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        cell_s     = full_sub(a_sh_r[0], b_sh_r[0], brw_r);
        res_next_s = {cell_s[0], res_r[WIDTH-1:1]};
        case (state_r)
            IDLE: begin
                if (start) begin
                    a_sh_s  = a;
                    b_sh_s  = b;
                    brw_s   = bin;
                    cnt_s   = {CW{1'b0}};
                    res_s   = {WIDTH{1'b0}};
                    busy_s  = 1'b1;
                    state_s = RUN;
                end else begin
                    busy_s  = 1'b0;
                end
            end
            RUN: begin
                a_sh_s = {1'b0, a_sh_r[WIDTH-1:1]};
                b_sh_s = {1'b0, b_sh_r[WIDTH-1:1]};
                res_s  = res_next_s;
                brw_s  = cell_s[1];
                if (cnt_r == LAST_BIT) begin
                    // Final bit: publish the whole result at once.
                    diff_s  = res_next_s;
                    bout_s  = cell_s[1];
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    cnt_s   = {CW{1'b0}};
                    state_s = IDLE;
                end else begin
                    cnt_s   = cnt_r + CW'(1);
                    busy_s  = 1'b1;
                end
            end
            default: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            a_sh_r  <= {WIDTH{1'b0}};
            b_sh_r  <= {WIDTH{1'b0}};
            res_r   <= {WIDTH{1'b0}};
            diff_r  <= {WIDTH{1'b0}};
            brw_r   <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            bout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            a_sh_r  <= a_sh_s;
            b_sh_r  <= b_sh_s;
            res_r   <= res_s;
            diff_r  <= diff_s;
            brw_r   <= brw_s;
            cnt_r   <= cnt_s;
            bout_r  <= bout_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

endmodule
